// File: rtl/mem_access_ctrl.sv
// CPU load/store to single-beat memory bus controller: size/alignment checks,
// byte-lane steering, load extension and a request timeout.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [1:0]  Size_i,
  input  logic        Unsigned_i,
  input  logic [31:0] Address_i,
  input  logic [31:0] WriteData_i,
  output logic [31:0] ReadData_o,
  output logic        Stall_o,
  output logic        Fault_o,
  output logic [1:0]  FaultCause_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  // state | meaning
  // IDLE  | waiting for a CPU access; decode and check it
  // REQ   | memory request held until ack or timeout
  // DONE  | access complete, CPU released for one cycle
  // FAULT | one-cycle fault pulse, no memory request issued
  typedef enum logic [1:0] {IDLE, REQ, DONE, FAULT} state_t;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      state_q;
  logic [15:0] wait_q;
  logic [31:0] rdata_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  off_q;
  logic [1:0]  cause_q;

  logic        req_any;
  logic        bad_size;
  logic        misalign;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] shifted;
  logic [31:0] load_ext;

  assign req_any  = MemRead_i | MemWrite_i;
  assign bad_size = (Size_i == 2'b11);
  assign misalign = ((Size_i == 2'b01) && Address_i[0]) ||
                    ((Size_i == 2'b10) && (Address_i[1:0] != 2'b00));

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = WriteData_i;
    case (Size_i)
      2'b00: begin
        be_d    = 4'b0001 << Address_i[1:0];
        wdata_d = {4{WriteData_i[7:0]}};
      end
      2'b01: begin
        be_d    = Address_i[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{WriteData_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Word loads are always aligned, so the shift is a no-op for them.
  assign shifted = mem_rdata_i >> {off_q, 3'b000};

  always_comb begin
    load_ext = shifted;
    case (size_q)
      2'b00:   load_ext = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
      2'b01:   load_ext = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      wait_q  <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      off_q   <= '0;
      cause_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_any) begin
            if (bad_size) begin
              cause_q <= 2'b00;
              state_q <= FAULT;
            end else if (misalign) begin
              cause_q <= MemRead_i ? 2'b01 : 2'b10;
              state_q <= FAULT;
            end else begin
              addr_q  <= {Address_i[31:2], 2'b00};
              be_q    <= be_d;
              wdata_q <= wdata_d;
              we_q    <= ~MemRead_i;
              size_q  <= Size_i;
              uns_q   <= Unsigned_i;
              off_q   <= Address_i[1:0];
              wait_q  <= '0;
              state_q <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_ack_i) begin
            if (!we_q) rdata_q <= load_ext;
            state_q <= DONE;
          end else if (wait_q == WAIT_LAST) begin
            cause_q <= 2'b11;
            state_q <= FAULT;
          end else begin
            wait_q <= wait_q + 16'd1;
          end
        end
        DONE:    state_q <= IDLE;
        FAULT:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stall is gated by reset so the CPU is released the instant reset asserts.
  assign Stall_o      = rst_n_i & (((state_q == IDLE) & req_any) | (state_q == REQ));
  assign Fault_o      = (state_q == FAULT);
  assign mem_req_o    = (state_q == REQ);
  assign mem_we_o     = we_q;
  assign mem_addr_o   = addr_q;
  assign mem_be_o     = be_q;
  assign mem_wdata_o  = wdata_q;
  assign ReadData_o   = rdata_q;
  assign FaultCause_o = cause_q;

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 64, SHALL set the number of REQ cycles without mem_ack_i before a timeout fault.
REQ-002 clk_i  in  1  SHALL be the single clock; all state SHALL update on the rising edge.
REQ-003 rst_n_i  in  1  SHALL be the reset, asynchronous and active-low.
REQ-004 MemRead_i  in  1  SHALL be the CPU load request; it is held stable while Stall_o=1.
REQ-005 MemWrite_i  in  1  SHALL be the CPU store request; it is held stable while Stall_o=1.
REQ-006 Size_i  in  2  SHALL encode the access size: 00 byte, 01 half, 10 word, 11 reserved.
REQ-007 Unsigned_i  in  1  SHALL select zero-extension (1) or sign-extension (0) for loads.
REQ-008 Address_i  in  32  SHALL be the CPU byte address.
REQ-009 WriteData_i  in  32  SHALL be the store data, right-aligned.
REQ-010 ReadData_o  out  32  SHALL be the extended load result.
REQ-011 Stall_o  out  1  SHALL freeze the CPU while an access is in progress.
REQ-012 Fault_o  out  1  SHALL be a one-cycle access-fault pulse.
REQ-013 FaultCause_o  out  2  SHALL give the fault cause: 00 bad size, 01 misaligned load, 10 misaligned store, 11 timeout.
REQ-014 mem_req_o  out  1  SHALL be the memory request.
REQ-015 mem_we_o  out  1  SHALL be the memory write enable; 0 means read.
REQ-016 mem_addr_o  out  32  SHALL be the word-aligned memory address {Address_i[31:2],2'b00}.
REQ-017 mem_be_o  out  4  SHALL be the byte-lane enables; bit n covers bits [8n+7:8n].
REQ-018 mem_wdata_o  out  32  SHALL be the lane-replicated store data.
REQ-019 mem_ack_i  in  1  SHALL be the memory completion strobe.
REQ-020 mem_rdata_i  in  32  SHALL be the read word, valid when mem_ack_i=1.

Function
REQ-021 The FSM SHALL have states IDLE, REQ, DONE and FAULT.
REQ-022 IDLE: if MemRead_i or MemWrite_i is 1, Stall_o SHALL be 1 combinationally; the next state SHALL be FAULT on a bad size or misalignment, otherwise REQ with address, size, data and direction registered.
REQ-023 When MemRead_i and MemWrite_i are both 1, the access SHALL be treated as a load.
REQ-024 Misalignment SHALL be defined as half with Address_i[0]=1, or word with Address_i[1:0]!=00; size 11 SHALL give cause 00 and takes precedence over misalignment.
REQ-025 REQ: mem_req_o=1 and Stall_o=1; mem_addr_o, mem_we_o, mem_be_o and mem_wdata_o SHALL remain constant until mem_ack_i is sampled 1, after which the next state SHALL be DONE.
REQ-026 mem_be_o SHALL be: byte 0001<<offset; half 0011 or 1100 per Address_i[1]; word 1111.
REQ-027 mem_wdata_o SHALL be: byte {4{WriteData_i[7:0]}}; half {2{WriteData_i[15:0]}}; word WriteData_i.
REQ-028 On a load ack, the selected lane SHALL be extended per Unsigned_i and registered into ReadData_o; stores SHALL NOT change ReadData_o.
REQ-029 DONE: Stall_o=0 for exactly one cycle; the next state SHALL be IDLE unconditionally.
REQ-030 Minimum access (ack in the first REQ cycle) SHALL be IDLE, REQ, DONE: 3 cycles with Stall_o high for 2 cycles.
REQ-031 A 16-bit wait counter SHALL clear on entry to REQ and increment each REQ cycle without ack; when it reaches TIMEOUT_CYC-1 without ack, the next state SHALL be FAULT with cause 11 and mem_req_o dropped.
REQ-032 FAULT: Fault_o=1 and Stall_o=0 for one cycle; FaultCause_o SHALL hold its value until the next fault; the next state SHALL be IDLE; no memory request SHALL be issued.
REQ-033 mem_ack_i SHALL be ignored outside REQ.
REQ-034 ReadData_o SHALL hold its last load value indefinitely.

Reset
REQ-035 rst_n_i=0 SHALL immediately force IDLE, with mem_req_o, mem_we_o, Stall_o and Fault_o at 0, and ReadData_o, mem_addr_o, mem_be_o, mem_wdata_o, FaultCause_o and the wait counter at 0, including mid-REQ.
REQ-036 After rst_n_i deasserts, the first edge SHALL evaluate IDLE normally.

Verification
REQ-037 lb with Address_i=0x13 and Unsigned_i=0, with ack in the first cycle returning rdata 0x80FF_FF00 -> mem_addr_o=0x10 and mem_be_o=1000; in DONE, ReadData_o=0xFFFFFF80 and Stall_o has been high for 2 cycles.
REQ-038 sh with Address_i=0x22 and WriteData_i=0x1234ABCD -> mem_we_o=1, mem_be_o=1100, mem_wdata_o=0xABCDABCD; ReadData_o is unchanged.
REQ-039 lw with Address_i=0x06 -> no mem_req_o; Fault_o pulses with FaultCause_o=01; Stall_o is high 1 cycle.
REQ-040 lw with no ack and TIMEOUT_CYC=4 -> mem_req_o high for 4 cycles, then Fault_o with FaultCause_o=11.
REQ-041 Reset asserted during REQ with ack delayed 5 cycles -> mem_req_o=0 immediately; a late ack after reset is ignored and ReadData_o=0.
REQ-042 MemRead_i and MemWrite_i both 1 with Size_i=10 -> mem_we_o=0, a load is performed, and a back-to-back second load issues a request in the cycle after DONE.
